// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain CLK/DAT via output enables.
// Define PS2_HOST_TX_RETRY_EN to retry a failed frame twice before reporting tx_error.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES       = 6000,
    parameter int unsigned START_TIMEOUT_CYCLES = 750000,
    parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000,
    parameter int unsigned CNT_W                = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned FRAME_W = 10;
    localparam int unsigned BCNT_W  = 4;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_DATA,
        S_ACK,
        S_RELEASE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [BCNT_W-1:0]   bit_idx_c;
    logic                final_c;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic fall_c;

    logic clk_oe_q, clk_oe_d;
    logic dat_oe_q, dat_oe_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic error_q, error_d;

    // Two-flop synchronizers; idle bus level is high
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_dat_in;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall_c = clk_prev_q & ~clk_s2_q;

`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0] retry_q, retry_d;

    // Third consecutive failure of the same frame is the one reported
    assign final_c = (retry_q == 2'd2);

    always_comb begin
        retry_d = retry_q;
        if (state_q == S_IDLE && tx_start) begin
            retry_d = 2'd0;
        end else if (state_q == S_FAIL && !final_c) begin
            retry_d = retry_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retry_q <= 2'd0;
        end else begin
            retry_q <= retry_d;
        end
    end
`else
    assign final_c = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus timer / bit-count / frame updates
    always_comb begin
        state_d = state_q;
        timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + CNT_W'(1);
        bcnt_d  = bcnt_q;
        frame_d = frame_q;
        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                bcnt_d  = '0;
                if (tx_start) begin
                    frame_d = {1'b1, ~^tx_data, tx_data};
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (timer_q == INHIBIT_LAST) begin
                    timer_d = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (fall_c) begin
                    bcnt_d  = BCNT_W'(1);
                    timer_d = '0;
                    state_d = S_DATA;
                end else if (timer_q == START_LAST) begin
                    state_d = S_FAIL;
                end
            end
            S_DATA: begin
                if (timer_q == XFER_LAST) begin
                    state_d = S_FAIL;
                end else if (fall_c) begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                    if (bcnt_q == BCNT_W'(FRAME_W - 1)) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (timer_q == XFER_LAST) begin
                    state_d = S_FAIL;
                end else if (fall_c) begin
                    state_d = dat_s2_q ? S_FAIL : S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (timer_q == XFER_LAST) begin
                    state_d = S_FAIL;
                end else if (clk_s2_q && dat_s2_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAIL: begin
                timer_d = '0;
                bcnt_d  = '0;
                state_d = final_c ? S_IDLE : S_INHIBIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame bit currently on the wire: count k means bit k-1 is being driven
    assign bit_idx_c = bcnt_d - BCNT_W'(1);

    // Outputs are decoded from the upcoming state and registered
    always_comb begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        error_d  = 1'b0;
        unique case (state_d)
            S_IDLE:    busy_d   = 1'b0;
            S_INHIBIT: clk_oe_d = 1'b1;
            S_REQ:     dat_oe_d = 1'b1;
            S_DATA:    dat_oe_d = ~frame_q[bit_idx_c];
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            S_FAIL: begin
                if (final_c) begin
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q  <= '0;
            bcnt_q   <= '0;
            frame_q  <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            bcnt_q   <= bcnt_d;
            frame_q  <= frame_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 keyboard model on open-drain lines.
// Retry expectations follow PS2_HOST_TX_RETRY_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH      = 50;
    localparam int STO      = 400;
    localparam int XTO      = 3000;
    localparam int H        = 20;
    localparam int REQ_WAIT = 1500;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int ATT = 3;
`else
    localparam int ATT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;

    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic dev_abort = 1'b0;
    int   dev_rise = 0;

    int checks = 0;
    int errors = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, req_cnt = 0, req_cyc = 0, err_cyc = 0;

    // Open-drain wired-AND of host and device
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT_CYCLES(STO),
        .XFER_TIMEOUT_CYCLES(XTO),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_error(tx_error),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Odd parity: parity bit makes the total count of ones odd
    function automatic logic par_of(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return (ones % 2 == 0);
    endfunction

    // Per-cycle rule checks plus event bookkeeping for the directed tests
    initial begin
        int   inh_run;
        logic prev_done, prev_err, prev_clk_oe;
        inh_run = 0; prev_done = 1'b0; prev_err = 1'b0; prev_clk_oe = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("done_err_excl", 32'(tx_done & tx_error), 0);
            chk("oe_excl", 32'(ps2_clk_oe & ps2_dat_oe), 0);
            chk("done_width", 32'(prev_done & tx_done), 0);
            chk("error_width", 32'(prev_err & tx_error), 0);
            if (!tx_busy) chk("idle_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
            if (ps2_clk_oe) begin
                inh_run++;
            end else if (inh_run != 0) begin
                chk("inhibit_len", inh_run, INH);
                inh_run = 0;
            end
            if (prev_clk_oe && !ps2_clk_oe && ps2_dat_oe) begin
                req_cnt++;
                req_cyc = cyc;
            end
            if (tx_done) done_cnt++;
            if (tx_error) begin
                err_cnt++;
                err_cyc = cyc;
            end
            prev_done = tx_done; prev_err = tx_error; prev_clk_oe = ps2_clk_oe;
            cyc++;
        end
    end

    // Keyboard model: waits for a request, clocks 11 times, reads bits at rising edges
    task automatic dev_frame(input bit do_ack, output logic [9:0] rx, output bit ok);
        int n;
        ok = 1'b0;
        rx = '0;
        n = 0;
        while (!(ps2_clk_in && !ps2_dat_in) && n < REQ_WAIT && !dev_abort) begin
            @(negedge clk);
            n++;
        end
        if (n >= REQ_WAIT || dev_abort) return;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            if (k < 10) rx[k] = ps2_dat_in;
            dev_clk = 1'b1;
            dev_rise = k + 1;
            repeat (H / 2) @(negedge clk);
            if (k == 9 && do_ack) dev_dat = 1'b0;
            repeat (H - H / 2) @(negedge clk);
            if (dev_abort) begin
                dev_clk = 1'b1;
                dev_dat = 1'b1;
                return;
            end
        end
        dev_dat = 1'b1;
        ok = 1'b1;
    endtask

    task automatic pulse_start(input logic [7:0] b);
        @(posedge clk); #1;
        tx_data  = b;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_outcome(input int d0, input int e0, input int limit, input string name);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_outcome_timeout"}, 32'(n >= limit), 0);
    endtask

    task automatic check_xfer(input logic [7:0] b, input logic [9:0] rx, input bit ok,
                              input int d0, input int e0, input bit exp_done, input string name);
        chk({name, "_frame_ok"}, 32'(ok), 1);
        chk({name, "_data"}, 32'(rx[7:0]), 32'(b));
        chk({name, "_parity"}, 32'(rx[8]), 32'(par_of(b)));
        chk({name, "_stop"}, 32'(rx[9]), 1);
        chk({name, "_done_cnt"}, done_cnt - d0, 32'(exp_done));
        chk({name, "_err_cnt"}, err_cnt - e0, 32'(!exp_done));
        @(negedge clk);
        chk({name, "_busy_after"}, 32'(tx_busy), 0);
    endtask

    initial begin
        logic [9:0] rx;
        bit         ok;
        int         d0, e0, r0, n;

        // Reset held with tx_start asserted: nothing accepted, outputs quiet
        tx_start = 1'b1;
        tx_data  = 8'hED;
        repeat (2) begin
            @(negedge clk);
            chk("rst_busy", 32'(tx_busy), 0);
            chk("rst_done", 32'(tx_done), 0);
            chk("rst_error", 32'(tx_error), 0);
            chk("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
        end
        reset = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        @(posedge clk); #1;
        tx_start = 1'b0;
        @(negedge clk);
        chk("accept_busy", 32'(tx_busy), 1);
        chk("accept_clk_oe", 32'(ps2_clk_oe), 1);
        dev_frame(1'b1, rx, ok);
        wait_outcome(d0, e0, 200, "ed");
        check_xfer(8'hED, rx, ok, d0, e0, 1'b1, "ed");
        chk("ed_frame_literal", 32'(rx), 32'h3ED);

        // 0xFF: parity bit 1, line released during parity
        d0 = done_cnt; e0 = err_cnt;
        pulse_start(8'hFF);
        @(negedge clk);
        chk("ff_busy", 32'(tx_busy), 1);
        dev_frame(1'b1, rx, ok);
        wait_outcome(d0, e0, 200, "ff");
        check_xfer(8'hFF, rx, ok, d0, e0, 1'b1, "ff");
        chk("ff_frame_literal", 32'(rx), 32'h3FF);

        // Device never clocks: start timeout
        d0 = done_cnt; e0 = err_cnt; r0 = req_cnt;
        pulse_start(8'hF4);
        wait_outcome(d0, e0, ATT * (INH + STO + 10) + 100, "sto");
        chk("sto_err_cnt", err_cnt - e0, 1);
        chk("sto_done_cnt", done_cnt - d0, 0);
        chk("sto_latency", err_cyc - req_cyc, STO);
        chk("sto_attempts", req_cnt - r0, ATT);
        @(negedge clk);
        chk("sto_busy", 32'(tx_busy), 0);
        chk("sto_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);

        // NACK at the ACK edge
        d0 = done_cnt; e0 = err_cnt; r0 = req_cnt;
        pulse_start(8'hA5);
        for (int a = 0; a < ATT; a++) dev_frame(1'b0, rx, ok);
        wait_outcome(d0, e0, 200, "nack");
        check_xfer(8'hA5, rx, ok, d0, e0, 1'b0, "nack");
        chk("nack_attempts", req_cnt - r0, ATT);

        // tx_start mid-frame with another byte is ignored
        d0 = done_cnt; e0 = err_cnt;
        pulse_start(8'hF4);
        dev_rise = 0;
        fork
            dev_frame(1'b1, rx, ok);
            begin
                n = 0;
                while (dev_rise < 4 && n < 2000) begin
                    @(posedge clk);
                    n++;
                end
                chk("mid_wait_bit4", 32'(n >= 2000), 0);
                @(posedge clk); #1;
                tx_data  = 8'h5A;
                tx_start = 1'b1;
                @(posedge clk); #1;
                tx_start = 1'b0;
            end
        join
        wait_outcome(d0, e0, 200, "mid");
        check_xfer(8'hF4, rx, ok, d0, e0, 1'b1, "mid");
        chk("mid_frame_literal", 32'(rx), 32'h2F4);

        // Reset at bit 6: lines released next edge, no pulses afterwards
        pulse_start(8'hC3);
        dev_rise = 0;
        fork
            dev_frame(1'b1, rx, ok);
            begin
                n = 0;
                while (dev_rise < 6 && n < 2000) begin
                    @(posedge clk);
                    n++;
                end
                chk("rst_wait_bit6", 32'(n >= 2000), 0);
                @(posedge clk); #1;
                reset     = 1'b1;
                dev_abort = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                chk("midrst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
                chk("midrst_busy", 32'(tx_busy), 0);
            end
        join
        dev_abort = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        repeat (100) @(posedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_error", err_cnt - e0, 0);

        // Recovery after reset
        d0 = done_cnt; e0 = err_cnt;
        pulse_start(8'h01);
        dev_frame(1'b1, rx, ok);
        wait_outcome(d0, e0, 200, "rec");
        check_xfer(8'h01, rx, ok, d0, e0, 1'b1, "rec");
        chk("rec_frame_literal", 32'(rx), 32'h201);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
